// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the 6502 memory arbiter.
package mem_arb_pkg;

   // Who owns the RAM port in the current cycle.
   typedef enum logic {
      S_CPU  = 1'b0,
      S_HOST = 1'b1
   } arb_state_t;

   localparam int ARB_ADDR_W = 16;
   localparam int ARB_DATA_W = 8;

endpackage

// File: rtl/mem_arbiter_6502.sv
// mem_arbiter_6502: shares one single-port synchronous RAM between the 6502
// core and a host port. The host steals cycles by pulling RDY low; the CPU
// read data is held across stolen cycles so the core sees its own read.
// Optional build macro MEM_ARB_FAIRNESS_EN: after HOST_BURST consecutive host
// cycles the CPU gets exactly one cycle back before the host is re-granted.
module mem_arbiter_6502
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = ARB_ADDR_W,
   parameter int DATA_W     = ARB_DATA_W,
   parameter int HOST_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   // CPU side
   input  logic [ADDR_W-1:0] cpu_ab,
   input  logic [DATA_W-1:0] cpu_do,
   input  logic              cpu_we,
   output logic [DATA_W-1:0] cpu_di,
   output logic              cpu_rdy,
   // host side
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   // RAM side
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t        r_state;
   arb_state_t        w_next;
   logic              r_di_sel;
   logic [DATA_W-1:0] r_di_hold;
   logic              w_force_cpu;

`ifdef MEM_ARB_FAIRNESS_EN
   localparam int RUN_W = $clog2(HOST_BURST) + 1;
   logic [RUN_W-1:0] r_run;

   // Count consecutive host cycles; any CPU cycle restarts the run.
   always_ff @(posedge clk) begin
      if (reset)                r_run <= '0;
      else if (r_state == S_HOST) r_run <= r_run + RUN_W'(1);
      else                      r_run <= '0;
   end

   // The current host cycle is the last one of the allowed burst.
   assign w_force_cpu = (r_run == RUN_W'(HOST_BURST - 1));
`else
   // No burst limit: the host keeps the RAM for as long as it requests.
   assign w_force_cpu = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_CPU;
      else       r_state <= w_next;
   end

   // Next-state and RAM port mux.
   always_comb begin
      w_next    = r_state;
      mem_addr  = cpu_ab;
      mem_we    = cpu_we;
      mem_wdata = cpu_do;
      case (r_state)
         S_CPU: begin
            if (host_req) w_next = S_HOST;
         end
         S_HOST: begin
            mem_addr  = host_addr;
            // A host that has already dropped its request leaves an idle
            // stolen cycle; never let it write in that cycle.
            mem_we    = host_we & host_req;
            mem_wdata = host_wdata;
            if (!host_req || w_force_cpu) w_next = S_CPU;
         end
         default: w_next = S_CPU;
      endcase
   end

   assign cpu_rdy  = (r_state == S_CPU);
   assign host_gnt = (r_state == S_HOST);

   // Host read data arrives one cycle after a granted, still-requested read.
   always_ff @(posedge clk) begin
      if (reset) host_rvalid <= 1'b0;
      else       host_rvalid <= (r_state == S_HOST) & host_req & ~host_we;
   end

   assign host_rdata = mem_rdata;

   // Capture RAM data only when it answers a CPU address, so a host read
   // cannot overwrite what the core is waiting for.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_di_sel  <= 1'b0;
         r_di_hold <= '0;
      end else begin
         r_di_sel  <= (r_state == S_CPU);
         if (r_di_sel) r_di_hold <= mem_rdata;
      end
   end

   assign cpu_di = r_di_sel ? mem_rdata : r_di_hold;

endmodule
